axis_msg_assembler: RTL and testbench
=====================================

# axis_msg_assembler

Parametrised AXI-Stream slave that assembles variable-length packets into whole messages of up to MAX_MSG_BYTES, LSB-first. It counts bytes from s_tkeep, so partial beats anywhere in the packet are handled. It detects overflow, bad keep patterns, empty packets and upstream errors. Its output register has a valid/ready handshake, so the consumer can apply backpressure. It replaces the fixed-width message parser at the same point in the receive path and presents the same message fields.

## Interface
- MAX_MSG_BYTES, 32, message buffer capacity in bytes (≥1)
- DATA_BYTES, 8, AXI-Stream beat width in bytes (≥1, power of two)
- LEN_WIDTH, 16, width of msg_length; must satisfy 2^LEN_WIDTH > MAX_MSG_BYTES
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset); deassertion synchronised externally
- s_tvalid  in  1  beat valid
- s_tready  out  1  beat accepted when s_tvalid & s_tready
- s_tdata  in  8*DATA_BYTES  beat data, byte 0 on [7:0]
- s_tkeep  in  DATA_BYTES  byte enables
- s_tlast  in  1  last beat of packet
- s_tuser  in  1  upstream error; sampled only on the tlast beat
- msg_valid  out  1  message held in output register
- msg_ready  in  1  consumer accepts the message when msg_valid & msg_ready
- msg_length  out  LEN_WIDTH  total bytes received, saturating at 2^LEN_WIDTH-1
- msg_data  out  8*MAX_MSG_BYTES  first MAX_MSG_BYTES bytes; bytes at or above msg_length read 0
- msg_error  out  1  OR of msg_err_flags
- msg_err_flags  out  4  [0] tuser, [1] overflow, [2] non-contiguous keep, [3] empty packet

## Operation
- Accumulator state: acc_data, acc_len (LEN_WIDTH) and acc_flags.
- On an accepted beat:
  - beat byte count n = popcount(s_tkeep);
  - kept bytes are compacted and written at byte offset acc_len;
  - acc_len += n, saturating at 2^LEN_WIDTH-1.
- Bytes whose destination offset is ≥ MAX_MSG_BYTES are dropped and set the overflow flag. Beats keep being accepted until tlast; the packet is never truncated early.
- Contiguous keep means the set bits form one run starting at bit 0, or s_tkeep = 0. Any other pattern sets flag[2]. Bytes are still packed in ascending lane order.
- s_tkeep = 0 on a non-last beat contributes 0 bytes and raises no error.
- tlast beat accepted:
  - flag[0] = s_tuser;
  - flag[3] is set if the final length is 0;
  - accumulator contents and final flags move to the output register, msg_valid = 1;
  - the accumulator clears in the same cycle.
- Output register states: EMPTY, FULL.
  - EMPTY→FULL on tlast accept.
  - FULL→EMPTY on msg_ready when no new tlast is accepted.
  - FULL→FULL on msg_ready with a simultaneous tlast accept (back-to-back reload).
- s_tready = rst & (!msg_valid | msg_ready). Backpressure applies to every beat, not only tlast.
- Outputs are stable while msg_valid & !msg_ready.

## Timing
- Latency: the tlast beat is accepted in cycle N; msg_valid is high in cycle N+1 with all fields valid.
- Throughput: one beat per cycle sustained, including single-beat packets on consecutive cycles, while msg_ready stays high.
- Reset values:
  - s_tready 0 while rst = 0, then 1;
  - msg_valid 0, msg_length 0, msg_data 0, msg_error 0, msg_err_flags 0;
  - accumulator cleared.
- Reset mid-packet discards the partial message. The first beat after reset starts a new message, even if the upstream continues the old packet.
- Reset while msg_valid = 1 drops the pending message.
- The saturated length still reports the overflow flag. Length never wraps.

## Configuration
- AXIS_MSG_STATS_EN defined adds two outputs:
  - stat_msg_count, 32 bits, counting messages handed off (msg_valid & msg_ready);
  - stat_err_count, 32 bits, counting handed-off messages with msg_error = 1.
- Both counters wrap modulo 2^32 and reset to 0.
- Without the macro these ports and counters do not exist. Datapath behaviour is identical either way.

## Structure
- Package axis_msg_pkg:
  - err_flags_t (4-bit packed struct);
  - index constants ERR_TUSER, ERR_OVERFLOW, ERR_KEEP, ERR_EMPTY;
  - functions keep_popcount() and keep_is_contiguous(), parametrised via DATA_BYTES.
- Sub-module axis_msg_byte_packer: combinational. Compacts kept lanes and produces the shifted write data/byte-mask at offset acc_len, with overflow detection. The FSM, accumulator and output register live in the top module.

## Test plan
- DATA_BYTES=8, MAX=32; 4 full beats, tlast on beat 4, tuser=0 → one message, length 32, data = bytes 0..31 in order, error 0, msg_valid the cycle after beat 4.
- Beats keep 0xFF, 0xFF, 0x07 + tlast → length 19, bytes 19..31 read 0, error 0.
- 5 full beats (40 bytes) → length 40, data = first 32 bytes, flags = 0b0010; s_tready high throughout.
- Beat keep 0x05 + tlast → flags[2] = 1; 2 bytes packed at offsets 0..1; length 2. Separately, a single beat keep 0x00 + tlast → length 0, flags = 0b1000.
- msg_ready held 0 for 10 cycles after a message → s_tready low, outputs stable. Then msg_ready = 1 with the next single-beat packet accepted in the same cycle → outputs reload with the next message with no empty cycle.
- rst pulsed low after 2 beats of a 4-beat packet, then a fresh 1-beat packet (keep 0x0F, tlast) → only one message appears, length 4. With AXIS_MSG_STATS_EN, stat_msg_count = 1 and stat_err_count = 0.

Source files
------------

// File: rtl/axis_msg_pkg.sv
// Shared types and helpers for the AXI-Stream message assembler.
// Error flag layout, output register states and tkeep helper functions.
package axis_msg_pkg;

    // Widest tkeep the helper functions accept; callers zero-extend into it.
    localparam int KEEP_MAX = 64;

    // Bit positions inside msg_err_flags.
    localparam int ERR_TUSER    = 0;
    localparam int ERR_OVERFLOW = 1;
    localparam int ERR_KEEP     = 2;
    localparam int ERR_EMPTY    = 3;

    // Packed so that bit 0 is tuser and bit 3 is empty.
    typedef struct packed {
        logic empty;
        logic keep;
        logic overflow;
        logic tuser;
    } err_flags_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // Number of set bits among the lowest data_bytes bits of keep.
    function automatic int unsigned keep_popcount(input logic [KEEP_MAX-1:0] keep,
                                                  input int unsigned data_bytes);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            if (i < data_bytes && keep[i]) cnt = cnt + 1;
        end
        return cnt;
    endfunction

    // True for keep = 0 or a single run of ones starting at bit 0.
    function automatic logic keep_is_contiguous(input logic [KEEP_MAX-1:0] keep,
                                                input int unsigned data_bytes);
        logic [KEEP_MAX-1:0] masked;
        masked = '0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            masked[i] = keep[i] && (i < data_bytes);
        end
        // A low-aligned run of ones plus one has no bits in common with itself.
        return (masked & (masked + 1'b1)) == '0;
    endfunction

endpackage

// File: rtl/axis_msg_byte_packer.sv
// Combinational byte packer: compacts the kept lanes of one beat and places
// them at byte offset 'offset' of the message buffer. Bytes that would land
// at or beyond MAX_MSG_BYTES are dropped and reported through 'overflow'.
module axis_msg_byte_packer
    import axis_msg_pkg::*;
#(
    parameter int MAX_MSG_BYTES = 32,
    parameter int DATA_BYTES    = 8,
    parameter int LEN_WIDTH     = 16
) (
    input  logic [8*DATA_BYTES-1:0]    data,
    input  logic [DATA_BYTES-1:0]      keep,
    input  logic [LEN_WIDTH-1:0]       offset,
    output logic [8*MAX_MSG_BYTES-1:0] wr_data,
    output logic [MAX_MSG_BYTES-1:0]   wr_mask,
    output logic                       overflow
);

    // Destination byte offset of each lane if it is kept.
    int unsigned dest [DATA_BYTES];

    // Rank each lane among the kept lanes below it and add the base offset.
    always_comb begin
        int unsigned rank;
        rank = 0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            dest[i] = 32'(offset) + rank;
            if (keep[i]) rank = rank + 1;
        end
    end

    // Route every kept lane to its destination byte, or flag it as dropped.
    always_comb begin
        wr_data  = '0;
        wr_mask  = '0;
        overflow = 1'b0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (keep[i] && dest[i] >= MAX_MSG_BYTES) overflow = 1'b1;
            for (int unsigned j = 0; j < MAX_MSG_BYTES; j++) begin
                if (keep[i] && dest[i] == j) begin
                    wr_mask[j]        = 1'b1;
                    wr_data[8*j +: 8] = data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axis_msg_assembler.sv
// AXI-Stream slave that assembles packets into whole messages, LSB-first,
// and hands them to a consumer through a valid/ready output register.
// Optional feature: define AXIS_MSG_STATS_EN to add handoff/error counters.
//
// Handshakes: an input beat transfers on a rising edge where
// s_tvalid & s_tready; a message transfers where msg_valid & msg_ready.
// s_tready depends only on reset, msg_valid and msg_ready, never on s_tvalid.
module axis_msg_assembler
    import axis_msg_pkg::*;
#(
    parameter int MAX_MSG_BYTES = 32,
    parameter int DATA_BYTES    = 8,
    parameter int LEN_WIDTH     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [8*DATA_BYTES-1:0]    s_tdata,
    input  logic [DATA_BYTES-1:0]      s_tkeep,
    input  logic                       s_tlast,
    input  logic                       s_tuser,
    output logic                       msg_valid,
    input  logic                       msg_ready,
    output logic [LEN_WIDTH-1:0]       msg_length,
    output logic [8*MAX_MSG_BYTES-1:0] msg_data,
    output logic                       msg_error,
    output logic [3:0]                 msg_err_flags,
    output out_state_t                 out_state
`ifdef AXIS_MSG_STATS_EN
    ,
    output logic [31:0]                stat_msg_count,
    output logic [31:0]                stat_err_count
`endif
);

    // Accumulator for the packet currently being received.
    logic [8*MAX_MSG_BYTES-1:0] acc_data;
    logic [LEN_WIDTH-1:0]       acc_len;
    err_flags_t                 acc_flags;

    // Packer results for the beat on the bus.
    logic [8*MAX_MSG_BYTES-1:0] wr_data;
    logic [MAX_MSG_BYTES-1:0]   wr_mask;
    logic                       beat_overflow;

    // Next accumulator contents if the current beat is accepted.
    logic [LEN_WIDTH:0]         len_sum;
    logic [LEN_WIDTH-1:0]       len_next;
    logic [8*MAX_MSG_BYTES-1:0] data_next;
    err_flags_t                 acc_upd;
    err_flags_t                 flags_next;

    out_state_t state;
    logic       accept;
    logic       load;

    assign s_tready  = rst & (~msg_valid | msg_ready);
    assign accept    = s_tvalid & s_tready;
    assign load      = accept & s_tlast;
    assign out_state = state;

    axis_msg_byte_packer #(
        .MAX_MSG_BYTES(MAX_MSG_BYTES),
        .DATA_BYTES   (DATA_BYTES),
        .LEN_WIDTH    (LEN_WIDTH)
    ) u_packer (
        .data    (s_tdata),
        .keep    (s_tkeep),
        .offset  (acc_len),
        .wr_data (wr_data),
        .wr_mask (wr_mask),
        .overflow(beat_overflow)
    );

    // Merge the beat into the accumulator image and derive the final flags.
    always_comb begin
        len_sum  = {1'b0, acc_len}
                 + (LEN_WIDTH+1)'(keep_popcount(KEEP_MAX'(s_tkeep), DATA_BYTES));
        len_next = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];

        data_next = acc_data;
        for (int j = 0; j < MAX_MSG_BYTES; j++) begin
            if (wr_mask[j]) data_next[8*j +: 8] = wr_data[8*j +: 8];
        end

        acc_upd          = acc_flags;
        acc_upd.overflow = acc_flags.overflow | beat_overflow;
        acc_upd.keep     = acc_flags.keep | !keep_is_contiguous(KEEP_MAX'(s_tkeep), DATA_BYTES);

        flags_next       = acc_upd;
        flags_next.tuser = s_tuser;
        flags_next.empty = (len_next == '0);
    end

    // Accumulator: grows on each accepted beat, clears when tlast is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_data  <= '0;
            acc_len   <= '0;
            acc_flags <= '0;
        end else if (accept) begin
            if (s_tlast) begin
                acc_data  <= '0;
                acc_len   <= '0;
                acc_flags <= '0;
            end else begin
                acc_data  <= data_next;
                acc_len   <= len_next;
                acc_flags <= acc_upd;
            end
        end
    end

    // Output register FSM: EMPTY until a message completes, FULL until taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= OUT_EMPTY;
            msg_valid     <= 1'b0;
            msg_length    <= '0;
            msg_data      <= '0;
            msg_err_flags <= '0;
            msg_error     <= 1'b0;
        end else begin
            case (state)
                OUT_EMPTY: begin
                    if (load) begin
                        state         <= OUT_FULL;
                        msg_valid     <= 1'b1;
                        msg_length    <= len_next;
                        msg_data      <= data_next;
                        msg_err_flags <= flags_next;
                        msg_error     <= |flags_next;
                    end
                end
                OUT_FULL: begin
                    // A load here implies msg_ready, so the old message is taken.
                    if (load) begin
                        msg_length    <= len_next;
                        msg_data      <= data_next;
                        msg_err_flags <= flags_next;
                        msg_error     <= |flags_next;
                    end else if (msg_ready) begin
                        state     <= OUT_EMPTY;
                        msg_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= OUT_EMPTY;
                    msg_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXIS_MSG_STATS_EN
    // Count handed-off messages and those among them carrying an error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_msg_count <= '0;
            stat_err_count <= '0;
        end else if (msg_valid && msg_ready) begin
            stat_msg_count <= stat_msg_count + 32'd1;
            if (msg_error) stat_err_count <= stat_err_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_msg_assembler.sv
// Testbench for axis_msg_assembler: directed packets with literal
// expectations, then randomized traffic against a packet-level model.
module tb_axis_msg_assembler;
    import axis_msg_pkg::*;

    localparam int MAXB = 32;
    localparam int DB   = 8;
    localparam int LW   = 16;
    localparam int W    = 8*MAXB;

    localparam int R_ON   = 0;
    localparam int R_RAND = 1;
    localparam int R_OFF  = 2;

    typedef struct packed {
        logic [8*DB-1:0] data;
        logic [DB-1:0]   keep;
        logic            last;
        logic            user;
    } beat_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            s_tvalid = 1'b0;
    logic            s_tready;
    logic [8*DB-1:0] s_tdata  = '0;
    logic [DB-1:0]   s_tkeep  = '0;
    logic            s_tlast  = 1'b0;
    logic            s_tuser  = 1'b0;
    logic            msg_valid;
    logic            msg_ready = 1'b0;
    logic [LW-1:0]   msg_length;
    logic [W-1:0]    msg_data;
    logic            msg_error;
    logic [3:0]      msg_err_flags;
    out_state_t      out_state;
`ifdef AXIS_MSG_STATS_EN
    logic [31:0]     stat_msg_count;
    logic [31:0]     stat_err_count;
`endif

    axis_msg_assembler #(
        .MAX_MSG_BYTES(MAXB),
        .DATA_BYTES   (DB),
        .LEN_WIDTH    (LW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tdata      (s_tdata),
        .s_tkeep      (s_tkeep),
        .s_tlast      (s_tlast),
        .s_tuser      (s_tuser),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .msg_length   (msg_length),
        .msg_data     (msg_data),
        .msg_error    (msg_error),
        .msg_err_flags(msg_err_flags),
        .out_state    (out_state)
`ifdef AXIS_MSG_STATS_EN
        ,
        .stat_msg_count(stat_msg_count),
        .stat_err_count(stat_err_count)
`endif
    );

    // ---------------- scoreboard / model state ----------------
    logic [W-1:0]    exp_q[$];     // expected message data, head = output register
    logic [LW+3:0]   meta_q[$];    // {length, flags} alongside exp_q
    logic [7:0]      pkt_q[$];     // bytes of the packet being received
    bit              pkt_bad = 0;
    logic [31:0]     exp_msg_count = '0;
    logic [31:0]     exp_err_count = '0;

    beat_t stim_q[$];
    beat_t cur = '0;
    bit    cur_valid = 0;
    int    rand_mode = 0;
    int    ready_mode = R_OFF;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model's output register.
    task automatic compare_outputs();
        logic [LW+3:0] meta;
        if (exp_q.size() != 0) begin
            meta = meta_q[0];
            check("msg_valid", W'(msg_valid), W'(1));
            check("msg_length", W'(msg_length), W'(meta[LW+3:4]));
            check("msg_data", msg_data, exp_q[0]);
            check("msg_err_flags", W'(msg_err_flags), W'(meta[3:0]));
            check("msg_error", W'(msg_error), W'(|meta[3:0]));
        end else begin
            check("msg_valid_idle", W'(msg_valid), W'(0));
        end
`ifdef AXIS_MSG_STATS_EN
        check("stat_msg_count", W'(stat_msg_count), W'(exp_msg_count));
        check("stat_err_count", W'(stat_err_count), W'(exp_err_count));
`endif
    endtask

    // Packet-level model: handoff frees the register, tlast completes a message.
    task automatic model_update(input bit acc);
        logic [W-1:0] d;
        logic [LW+3:0] meta;
        int cnt;
        int sz;
        if (exp_q.size() != 0 && msg_ready) begin
            meta = meta_q[0];
            exp_msg_count = exp_msg_count + 1;
            if (meta[3:0] != 0) exp_err_count = exp_err_count + 1;
            void'(exp_q.pop_front());
            void'(meta_q.pop_front());
        end
        if (acc) begin
            cnt = 0;
            for (int i = 0; i < DB; i++) begin
                if (cur.keep[i]) begin
                    pkt_q.push_back(cur.data[8*i +: 8]);
                    cnt++;
                end
            end
            if (!(cur.keep == 0 || cur.keep == DB'((1 << cnt) - 1))) pkt_bad = 1;
            if (cur.last) begin
                sz = pkt_q.size();
                d = '0;
                for (int j = 0; j < sz && j < MAXB; j++) d[8*j +: 8] = pkt_q[j];
                meta[LW+3:4] = (sz > 65535) ? LW'(65535) : LW'(sz);
                meta[3:0] = {sz == 0, pkt_bad, sz > MAXB, cur.user};
                exp_q.push_back(d);
                meta_q.push_back(meta);
                pkt_q.delete();
                pkt_bad = 0;
            end
        end
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        int k;
        b.data = {$urandom, $urandom};
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: b.keep = '1;
            5, 6: begin
                k = $urandom_range(0, DB);
                b.keep = DB'((1 << k) - 1);
            end
            7: b.keep = DB'($urandom);
            8: b.keep = '0;
            default: b.keep = '1;
        endcase
        b.last = ($urandom_range(0, 3) == 0);
        b.user = ($urandom_range(0, 7) == 0);
        return b;
    endfunction

    // ---------------- driver tasks ----------------
    // One clock cycle: check outputs, drive inputs, check s_tready, advance model.
    task automatic step();
        bit acc;
        @(negedge clk);
        compare_outputs();
        if (!cur_valid) begin
            if (stim_q.size() != 0) begin
                cur = stim_q.pop_front();
                cur_valid = 1;
            end else if (rand_mode != 0 && $urandom_range(0, 3) != 0) begin
                cur = rand_beat();
                cur_valid = 1;
            end
        end
        s_tvalid = cur_valid;
        s_tdata  = cur.data;
        s_tkeep  = cur.keep;
        s_tlast  = cur.last;
        s_tuser  = cur.user;
        case (ready_mode)
            R_ON:    msg_ready = 1'b1;
            R_RAND:  msg_ready = 1'($urandom_range(0, 1));
            default: msg_ready = 1'b0;
        endcase
        #1;
        acc = cur_valid && (exp_q.size() == 0 || msg_ready);
        check("s_tready", W'(s_tready), W'(exp_q.size() == 0 || msg_ready));
        model_update(acc);
        if (acc) cur_valid = 0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b0;
        s_tvalid = 1'b0;
        msg_ready = 1'b0;
        cur_valid = 0;
        stim_q.delete();
        exp_q.delete();
        meta_q.delete();
        pkt_q.delete();
        pkt_bad = 0;
        exp_msg_count = '0;
        exp_err_count = '0;
        #1;
        check("rst_s_tready", W'(s_tready), W'(0));
        check("rst_msg_valid", W'(msg_valid), W'(0));
        check("rst_msg_length", W'(msg_length), W'(0));
        check("rst_msg_data", msg_data, W'(0));
        check("rst_msg_err_flags", W'(msg_err_flags), W'(0));
        check("rst_msg_error", W'(msg_error), W'(0));
        repeat (cycles) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic push_beat(input logic [8*DB-1:0] d, input logic [DB-1:0] k,
                             input logic l, input logic u);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        b.user = u;
        stim_q.push_back(b);
    endtask

    // Run until every queued beat has been accepted.
    task automatic feed(input int budget);
        int k;
        k = 0;
        while ((stim_q.size() != 0 || cur_valid) && k < budget) begin
            step();
            k++;
        end
        check("feed_done", W'(stim_q.size() == 0 && !cur_valid), W'(1));
    endtask

    // Let the consumer take whatever is pending.
    task automatic drain(input int budget);
        int k;
        k = 0;
        ready_mode = R_ON;
        while (exp_q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        check("drain_done", W'(exp_q.size() == 0), W'(1));
    endtask

    function automatic logic [W-1:0] bytes_from(input int base, input int n);
        logic [W-1:0] w;
        w = '0;
        for (int j = 0; j < n && j < MAXB; j++) w[8*j +: 8] = 8'(base + j);
        return w;
    endfunction

    function automatic logic [8*DB-1:0] beat_from(input int base);
        logic [8*DB-1:0] w;
        for (int j = 0; j < DB; j++) w[8*j +: 8] = 8'(base + j);
        return w;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] w;
        do_reset(2);

        // Four full beats: exactly fills the buffer; valid the cycle after tlast.
        ready_mode = R_OFF;
        for (int b = 0; b < 4; b++) push_beat(beat_from(8*b), '1, b == 3, 1'b0);
        feed(20);
        step();
        check("t1_valid", W'(msg_valid), W'(1));
        check("t1_len", W'(msg_length), W'(32));
        check("t1_data", msg_data, bytes_from(0, 32));
        check("t1_flags", W'(msg_err_flags), W'(0));
        drain(20);

        // Partial last beat: 19 bytes, upper bytes zero.
        ready_mode = R_OFF;
        push_beat(beat_from(8'h40), 8'hFF, 1'b0, 1'b0);
        push_beat(beat_from(8'h48), 8'hFF, 1'b0, 1'b0);
        push_beat(beat_from(8'h50), 8'h07, 1'b1, 1'b0);
        feed(20);
        step();
        check("t2_len", W'(msg_length), W'(19));
        check("t2_data", msg_data, bytes_from(8'h40, 19));
        check("t2_error", W'(msg_error), W'(0));
        drain(20);

        // Five full beats: overflow, length keeps counting, no early truncation.
        ready_mode = R_OFF;
        for (int b = 0; b < 5; b++) push_beat(beat_from(8'h80 + 8*b), '1, b == 4, 1'b0);
        feed(20);
        step();
        check("t3_len", W'(msg_length), W'(40));
        check("t3_data", msg_data, bytes_from(8'h80, 32));
        check("t3_flags", W'(msg_err_flags), W'(1 << ERR_OVERFLOW));
        drain(20);

        // Non-contiguous keep 0x05: lanes 0 and 2 packed to offsets 0,1.
        ready_mode = R_OFF;
        push_beat(beat_from(8'hA0), 8'h05, 1'b1, 1'b0);
        feed(20);
        step();
        w = '0;
        w[7:0]  = 8'hA0;
        w[15:8] = 8'hA2;
        check("t4_len", W'(msg_length), W'(2));
        check("t4_data", msg_data, w);
        check("t4_flags", W'(msg_err_flags), W'(1 << ERR_KEEP));
        drain(20);

        // Empty packet.
        ready_mode = R_OFF;
        push_beat(beat_from(8'h11), 8'h00, 1'b1, 1'b0);
        feed(20);
        step();
        check("t4b_len", W'(msg_length), W'(0));
        check("t4b_flags", W'(msg_err_flags), W'(1 << ERR_EMPTY));
        check("t4b_error", W'(msg_error), W'(1));
        drain(20);

        // Backpressure for 10 cycles, then back-to-back reload.
        ready_mode = R_OFF;
        push_beat(beat_from(8'h60), 8'hFF, 1'b1, 1'b1);
        feed(20);
        push_beat(beat_from(8'hC0), 8'h0F, 1'b1, 1'b0);
        repeat (10) step();
        check("t5_stall_ready", W'(s_tready), W'(0));
        check("t5_stall_len", W'(msg_length), W'(8));
        check("t5_stall_flags", W'(msg_err_flags), W'(1 << ERR_TUSER));
        ready_mode = R_ON;
        step();
        ready_mode = R_OFF;
        step();
        check("t5_reload_valid", W'(msg_valid), W'(1));
        check("t5_reload_len", W'(msg_length), W'(4));
        check("t5_reload_data", msg_data, bytes_from(8'hC0, 4));
        drain(20);

        // Reset in the middle of a packet, then a fresh one-beat packet.
        ready_mode = R_OFF;
        push_beat(beat_from(8'h20), '1, 1'b0, 1'b0);
        push_beat(beat_from(8'h28), '1, 1'b0, 1'b0);
        feed(20);
        do_reset(2);
        push_beat(beat_from(8'hD0), 8'h0F, 1'b1, 1'b0);
        feed(20);
        step();
        check("t6_len", W'(msg_length), W'(4));
        check("t6_data", msg_data, bytes_from(8'hD0, 4));
        check("t6_flags", W'(msg_err_flags), W'(0));
        drain(20);
        step();
`ifdef AXIS_MSG_STATS_EN
        check("t6_stat_msg", W'(stat_msg_count), W'(1));
        check("t6_stat_err", W'(stat_err_count), W'(0));
`endif

        // Randomized traffic with random consumer backpressure.
        rand_mode = 1;
        ready_mode = R_RAND;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 799) == 0) begin
                do_reset(1);
                ready_mode = R_RAND;
            end
            step();
        end
        rand_mode = 0;
        feed(200);
        drain(50);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
